// File: rtl/vga_pkg.sv
// Shared constants and pixel types for the VGA output stage.
// Timing defaults describe 640x480@60 with one pixel per clock.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int FIFO_DEPTH = 4;
   localparam int FIFO_AW    = 2;

   localparam int R_MSB = 7;
   localparam int R_LSB = 6;
   localparam int G_MSB = 5;
   localparam int G_LSB = 4;
   localparam int B_MSB = 3;
   localparam int B_LSB = 2;

   typedef logic [7:0] pixel_t;

   typedef struct packed {
      logic [1:0] r;
      logic [1:0] g;
      logic [1:0] b;
   } rgb_t;

   // Bits [1:0] of a pixel carry nothing and are dropped here.
   function automatic rgb_t px_rgb(input pixel_t p);
      rgb_t c;
      c.r = p[R_MSB:R_LSB];
      c.g = p[G_MSB:G_LSB];
      c.b = p[B_MSB:B_LSB];
      return c;
   endfunction

endpackage

// File: rtl/vga_out_if.sv
// Pixel handshake from the upstream processing unit.
// Upstream holds stb/data until it sees a one-cycle ack.
interface vga_out_if;
   import vga_pkg::*;

   pixel_t data_i;
   logic   stb_i;
   logic   ack_i;

   modport master (
      output data_i,
      output stb_i,
      input  ack_i
   );

   modport slave (
      input  data_i,
      input  stb_i,
      output ack_i
   );

endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous pixel FIFO with an occupancy count.
// Caller never pushes when full nor pops when empty.
module pixel_fifo
   import vga_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = FIFO_AW
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  pixel_t        wdata,
   input  logic          pop,
   output pixel_t        rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   pixel_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   // Pointers wrap naturally; count moves only on an unpaired push or pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage; cleared on reset so discarded pixels never reappear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/vga_out.sv
// Final pixel stage: raster counters, sync generation and pixel FIFO.
// All video outputs are registered one cycle after the raster position.
module vga_out
   import vga_pkg::pixel_t;
   import vga_pkg::rgb_t;
   import vga_pkg::px_rgb;
#(
   parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
   parameter int H_FP       = vga_pkg::H_FP,
   parameter int H_SYNC     = vga_pkg::H_SYNC,
   parameter int H_BP       = vga_pkg::H_BP,
   parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
   parameter int V_FP       = vga_pkg::V_FP,
   parameter int V_SYNC     = vga_pkg::V_SYNC,
   parameter int V_BP       = vga_pkg::V_BP,
   parameter int FIFO_DEPTH = vga_pkg::FIFO_DEPTH,
   parameter int FIFO_AW    = vga_pkg::FIFO_AW
)
(
   input  logic       clk,
   input  logic       rst,
   vga_out_if.slave   up,
   output logic       frame_sync,
   output logic [1:0] vga_r,
   output logic [1:0] vga_g,
   output logic [1:0] vga_b,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic       underflow
);

   localparam logic [9:0] HA    = 10'(H_ACTIVE);
   localparam logic [9:0] VA    = 10'(V_ACTIVE);
   localparam logic [9:0] HS0   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS1   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS0   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS1   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] HT_M1 = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] VT_M1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic [9:0]       sx;
   logic [9:0]       sy;
   logic             end_x;
   logic             end_y;
   logic             visible;
   logic             hs_n;
   logic             vs_n;
   logic             accept;
   logic             pop;
   logic             full;
   logic             empty;
   logic             fifo_dry;
   logic [FIFO_AW:0] count;
   pixel_t           rdata;
   rgb_t             px;

   assign end_x    = (sx == HT_M1);
   assign end_y    = (sy == VT_M1);
   assign visible  = (sx < HA) && (sy < VA);
   assign hs_n     = !((sx >= HS0) && (sx < HS1));
   assign vs_n     = !((sy >= VS0) && (sy < VS1));
   assign accept   = up.stb_i && !up.ack_i && !full;
   assign pop      = visible && !empty;
   assign fifo_dry = (count == '0);
   assign px       = px_rgb(rdata);

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .wdata (up.data_i),
      .pop   (pop),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Raster position: sx runs every clock, sy steps on each line wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sx <= '0;
         sy <= '0;
      end else if (end_x) begin
         sx <= '0;
         sy <= end_y ? '0 : sy + 1'b1;
      end else begin
         sx <= sx + 1'b1;
      end
   end

   // One-cycle accept pulse; also blocks a back-to-back accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) up.ack_i <= 1'b0;
      else      up.ack_i <= accept;
   end

   // Registered video outputs, sticky underflow on a starved visible pixel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vga_r      <= '0;
         vga_g      <= '0;
         vga_b      <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         de         <= 1'b0;
         frame_sync <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         de         <= visible;
         hsync      <= hs_n;
         vsync      <= vs_n;
         frame_sync <= end_x && end_y;
         if (pop) begin
            vga_r <= px.r;
            vga_g <= px.g;
            vga_b <= px.b;
         end else begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
         end
         if (visible && fifo_dry) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_out.sv
// Bench for vga_out on a shrunken raster so whole frames fit in a short run.
// A queue-based reference model predicts every registered output each cycle.
module tb_vga_out;

   localparam int HA = 32;
   localparam int HF = 4;
   localparam int HS = 8;
   localparam int HB = 6;
   localparam int VA = 8;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int D  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_sync;
   logic [1:0] vga_r;
   logic [1:0] vga_g;
   logic [1:0] vga_b;
   logic       hsync;
   logic       vsync;
   logic       de;
   logic       underflow;

   vga_out_if bus ();

   always #5 clk = ~clk;

   vga_out #(
      .H_ACTIVE   (HA),
      .H_FP       (HF),
      .H_SYNC     (HS),
      .H_BP       (HB),
      .V_ACTIVE   (VA),
      .V_FP       (VF),
      .V_SYNC     (VS),
      .V_BP       (VB),
      .FIFO_DEPTH (D),
      .FIFO_AW    (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .up         (bus),
      .frame_sync (frame_sync),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b),
      .hsync      (hsync),
      .vsync      (vsync),
      .de         (de),
      .underflow  (underflow)
   );

   int vec = 0;
   int bad = 0;

   // reference model state
   int         t;
   bit         ack_m;
   logic [7:0] q[$];
   bit         e_de, e_hs, e_vs, e_fs, e_uf;
   logic [1:0] e_r, e_g, e_b;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vec++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got %0h exp %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   task automatic mreset();
      t     = 0;
      ack_m = 1'b0;
      q.delete();
      e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_uf = 1'b0;
      e_r = '0; e_g = '0; e_b = '0;
   endtask

   task automatic check_all();
      chk("ack", bus.ack_i, ack_m);
      chk("de", de, e_de);
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("frame_sync", frame_sync, e_fs);
      chk("vga_r", vga_r, e_r);
      chk("vga_g", vga_g, e_g);
      chk("vga_b", vga_b, e_b);
      chk("underflow", underflow, e_uf);
      chk("fifo_count", dut.u_fifo.count, q.size());
   endtask

   // Predict one clock from raster arithmetic and the pixel queue.
   task automatic tick();
      int         sx, sy, n;
      bit         vis, acc;
      logic [7:0] px;
      sx  = t % HT;
      sy  = (t / HT) % VT;
      vis = (sx < HA) && (sy < VA);
      n   = q.size();
      acc = (bus.stb_i === 1'b1) && !ack_m && (n < D);
      if (vis && n > 0) begin
         px  = q.pop_front();
         e_r = px[7:6]; e_g = px[5:4]; e_b = px[3:2];
      end else begin
         e_r = '0; e_g = '0; e_b = '0;
      end
      if (acc) q.push_back(bus.data_i);
      if (vis && n == 0) e_uf = 1'b1;
      ack_m = acc;
      e_de  = vis;
      e_hs  = !(sx >= HA + HF && sx < HA + HF + HS);
      e_vs  = !(sy >= VA + VF && sy < VA + VF + VS);
      e_fs  = ((t % FT) == FT - 1);
      t++;
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      int         hs_lo, vs_lo, fs_n, fs_t0, fs_gap, k, n_acc;
      logic [7:0] pat [3];
      logic [7:0] p5 [6];
      pat = '{8'hC0, 8'h30, 8'h0C};

      // reset state
      rst        = 1'b0;
      bus.stb_i  = 1'b0;
      bus.data_i = '0;
      mreset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b1;

      // two idle frames: sync widths, frame_sync period, underflow
      hs_lo = 0; vs_lo = 0; fs_n = 0; fs_t0 = -1; fs_gap = 0;
      for (int i = 0; i < 2 * FT; i++) begin
         tick();
         if (!hsync) hs_lo++;
         if (!vsync) vs_lo++;
         if (frame_sync) begin
            fs_n++;
            if (fs_t0 >= 0) fs_gap = i - fs_t0;
            fs_t0 = i;
         end
      end
      chk("hs_low_cycles", hs_lo, 2 * VT * HS);
      chk("vs_low_cycles", vs_lo, 2 * VS * HT);
      chk("fs_pulses", fs_n, 2);
      chk("fs_period", fs_gap, FT);
      chk("idle_underflow", underflow, 1'b1);

      // streaming upstream, new pixel right after each ack
      k          = 0;
      bus.stb_i  = 1'b1;
      bus.data_i = pat[0];
      for (int i = 0; i < 2 * FT; i++) begin
         tick();
         if (bus.ack_i) begin
            k++;
            bus.data_i = pat[k % 3];
         end
      end
      bus.stb_i = 1'b0;
      chk("stream_accepts_nonzero", (k > 0), 1'b1);

      // reset, then 6 pixels offered starting in line-0 blanking
      rst = 1'b0;
      #1;
      mreset();
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b1;
      while (t != HA) tick();
      p5[0] = 8'hFF;
      for (int i = 1; i < 6; i++) p5[i] = 8'($urandom);
      n_acc      = 0;
      bus.stb_i  = 1'b1;
      bus.data_i = p5[0];
      for (int g = 0; g < 200 && n_acc < 6; g++) begin
         tick();
         if (t == HT) begin
            chk("blank_accepts", n_acc, 4);
            chk("blank_full", dut.u_fifo.full, 1'b1);
         end
         if (t == HT + 1) begin
            chk("ff_r", vga_r, 2'd3);
            chk("ff_g", vga_g, 2'd3);
            chk("ff_b", vga_b, 2'd3);
            chk("ff_de", de, 1'b1);
         end
         if (bus.ack_i) begin
            n_acc++;
            if (n_acc == 5) chk("fifth_ack_time", t, HT + 2);
            if (n_acc < 6) bus.data_i = p5[n_acc];
            else bus.stb_i = 1'b0;
         end
         if (t == HT + 4) chk("pushpop_count", dut.u_fifo.count, 3'd2);
      end
      chk("accepted_six", n_acc, 6);

      // queue 3 in line-2 blanking, then reset mid-line
      while (t != 2 * HT + HA) tick();
      n_acc      = 0;
      bus.stb_i  = 1'b1;
      bus.data_i = 8'($urandom);
      for (int g = 0; g < 50 && n_acc < 3; g++) begin
         tick();
         if (bus.ack_i) begin
            n_acc++;
            bus.data_i = 8'($urandom);
            if (n_acc == 3) bus.stb_i = 1'b0;
         end
      end
      chk("queued_three", n_acc, 3);
      while (t != 2 * HT + HA + 12) tick();
      chk("pre_rst_count", dut.u_fifo.count, 3'd3);
      rst = 1'b0;
      #1;
      mreset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b1;
      tick();
      chk("post_rst_de", de, 1'b1);
      chk("post_rst_rgb", {vga_r, vga_g, vga_b}, 6'd0);
      chk("post_rst_uf", underflow, 1'b1);

      // random upstream traffic obeying hold-until-ack
      for (int i = 0; i < 2 * FT; i++) begin
         if (!bus.stb_i && $urandom_range(0, 2) != 0) begin
            bus.stb_i  = 1'b1;
            bus.data_i = 8'($urandom);
         end
         tick();
         if (bus.stb_i && bus.ack_i) begin
            bus.stb_i  = 1'($urandom_range(0, 1));
            bus.data_i = 8'($urandom);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
